// File: rtl/regfile_pkg.sv
// Shared widths, FSM encoding and FP buffer entry layout for the register-file
// writeback arbiter.
package regfile_pkg;

   localparam int unsigned N                    = 32;
   localparam int unsigned ADDRESS_SIZE         = 6;
   localparam int unsigned FIFO_DEPTH_DEFAULT   = 4;
   localparam int unsigned STARVE_LIMIT_DEFAULT = 8;

   typedef enum logic [1:0] {
      StIdle,
      StPend,
      StForce
   } wb_state_e;

   typedef struct packed {
      logic                    valid;
      logic [ADDRESS_SIZE-1:0] addr;
      logic [N-1:0]            data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular FP result buffer; each entry carries a valid bit that a parallel
// address match can clear so a younger integer write supersedes it.
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int unsigned Depth = FIFO_DEPTH_DEFAULT
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    push_i,
   input  wb_entry_t               push_entry_i,
   input  logic                    pop_i,
   input  logic                    kill_i,
   input  logic [ADDRESS_SIZE-1:0] kill_addr_i,
   output wb_entry_t               head_o,
   output logic [$clog2(Depth):0]  count_o,
   output logic                    full_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   wb_entry_t       mem_q [Depth];
   logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0] count_q;
   logic            do_push, do_pop, push_killed;

   always_comb begin
      full_o      = (count_q == CntW'(Depth));
      do_push     = push_i && !full_o;
      do_pop      = pop_i && (count_q != '0);
      // An entry arriving alongside a matching kill is already stale.
      push_killed = kill_i && (push_entry_i.addr == kill_addr_i);
      head_o      = mem_q[rd_ptr_q];
      count_o     = count_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < Depth; i++) begin
            if (kill_i && (mem_q[i].addr == kill_addr_i)) begin
               mem_q[i].valid <= 1'b0;
            end
         end
         if (do_push) begin
            mem_q[wr_ptr_q].valid <= push_entry_i.valid && !push_killed;
            mem_q[wr_ptr_q].addr  <= push_entry_i.addr;
            mem_q[wr_ptr_q].data  <= push_entry_i.data;
            wr_ptr_q              <= wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Sole register-file write port driver: merges integer writebacks with buffered
// FP results, preserving WAW order and bounding FP starvation.
module regfile_writeback_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEFAULT,
   parameter int unsigned STARVE_LIMIT  = STARVE_LIMIT_DEFAULT,
   parameter bit          HARDWIRE_ZERO = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         int_wr_en,
   input  logic [ADDRESS_SIZE-1:0]      int_rd_addr,
   input  logic [N-1:0]                 int_wr_data,
   output logic                         int_stall,
   input  logic                         fp_valid,
   output logic                         fp_ready,
   input  logic [ADDRESS_SIZE-1:0]      fp_rd_addr,
   input  logic [N-1:0]                 fp_wr_data,
   output logic                         write,
   output logic [ADDRESS_SIZE-1:0]      rd_address,
   output logic [N-1:0]                 write_data,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

   localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned WaitW = $clog2(STARVE_LIMIT + 1);

   wb_state_e       state_q;
   logic [WaitW-1:0] wait_cnt_q;
   wb_entry_t       head, push_entry;
   logic            fifo_full;
   logic            int_acc, int_live, push, pop, fp_write;
   logic [CntW-1:0] count_next;

   always_comb begin
      int_stall        = (state_q == StForce);
      int_acc          = int_wr_en && !int_stall;
      int_live         = int_acc && !(HARDWIRE_ZERO && (int_rd_addr == '0));
      fp_ready         = !fifo_full;
      push             = fp_valid && fp_ready;
      push_entry.valid = !(HARDWIRE_ZERO && (fp_rd_addr == '0));
      push_entry.addr  = fp_rd_addr;
      push_entry.data  = fp_wr_data;
      // A dead head is discarded even while int owns the write port.
      pop              = (fifo_count != '0) && (!int_acc || !head.valid);
      fp_write         = pop && head.valid;
      count_next       = fifo_count + CntW'(push) - CntW'(pop);
   end

   wb_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i        (clk),
      .rst_i        (reset),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .kill_i       (int_acc),
      .kill_addr_i  (int_rd_addr),
      .head_o       (head),
      .count_o      (fifo_count),
      .full_o       (fifo_full)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         write      <= 1'b0;
         rd_address <= '0;
         write_data <= '0;
      end else begin
         write <= int_live || fp_write;
         if (int_live) begin
            rd_address <= int_rd_addr;
            write_data <= int_wr_data;
         end else if (fp_write) begin
            rd_address <= head.addr;
            write_data <= head.data;
         end

         case (state_q)
            StIdle: begin
               wait_cnt_q <= '0;
               if (push) state_q <= StPend;
            end
            StPend: begin
               if (pop) begin
                  wait_cnt_q <= '0;
               end else if (wait_cnt_q < WaitW'(STARVE_LIMIT)) begin
                  wait_cnt_q <= wait_cnt_q + WaitW'(1);
               end
               if (fifo_full && (wait_cnt_q >= WaitW'(STARVE_LIMIT)) && !pop) begin
                  state_q <= StForce;
               end else if (count_next == '0) begin
                  state_q <= StIdle;
               end
            end
            StForce: begin
               wait_cnt_q <= '0;
               state_q    <= (count_next == '0) ? StIdle : StPend;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
